// File: rtl/irq_edge_arbiter8_if.sv
// rtl/irq_edge_arbiter8_if.sv - request/handshake bundle between interrupt sources, CPU and irq_edge_arbiter8
//
// Signals:
//   en          arbitration enable (driven by master)
//   req[7:0]    raw request lines, a 0->1 transition is an event (master)
//   mask[7:0]   1 = source excluded from arbitration (master)
//   ack         CPU accepts the presented interrupt (master)
//   eoi         CPU end-of-interrupt (master)
//   irq         interrupt presented (slave)
//   irq_id[2:0] index of presented / in-service source (slave)
//   pending     latched, unserviced events (slave)
//   in_service  high between accepted ack and eoi (slave)
//   timeout_err one-cycle pulse on ack timeout (slave)
interface irq_edge_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       in_service;
  logic       timeout_err;

  modport master (
    output en, req, mask, ack, eoi,
    input  irq, irq_id, pending, in_service, timeout_err
  );

  modport slave (
    input  en, req, mask, ack, eoi,
    output irq, irq_id, pending, in_service, timeout_err
  );
endinterface

// File: rtl/irq_edge_arbiter8.sv
// rtl/irq_edge_arbiter8.sv - eight-source edge-triggered fixed-priority interrupt arbiter with irq/ack/eoi handshake
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   irq_edge_arbiter8_if.slave: en, req, mask, ack, eoi in;
//         irq, irq_id, pending, in_service, timeout_err out
// Parameter:
//   ACK_TIMEOUT  max cycles irq stays high without ack; 0 disables
module irq_edge_arbiter8 #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  irq_edge_arbiter8_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Counter only needs to reach ACK_TIMEOUT-1; the timeout fires instead of
  // incrementing past that value.
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    req_q, req_d;
  logic [7:0]    pending_q, pending_d;
  logic          irq_q, irq_d;
  logic [2:0]    irq_id_q, irq_id_d;
  logic          in_service_q, in_service_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]    edge_evt;
  logic [7:0]    cand;
  logic [7:0]    clr;
  logic [2:0]    winner;

  assign edge_evt = bus.req & ~req_q;
  assign cand     = pending_q & ~bus.mask;

  // Fixed priority: scanning upward lets the highest set index overwrite.
  always_comb begin
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = bus.req;
    irq_d         = irq_q;
    irq_id_d      = irq_id_q;
    in_service_d  = in_service_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    clr           = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.en && (cand != 8'h00)) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          irq_id_d = winner;
          cnt_d    = '0;
        end
      end
      REQ: begin
        // ack beats both timeout and disable in the same cycle.
        if (bus.ack) begin
          clr          = 8'h01 << irq_id_q;
          state_d      = SERVICE;
          irq_d        = 1'b0;
          in_service_d = 1'b1;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          irq_d         = 1'b0;
          timeout_err_d = 1'b1;
        end else if (!bus.en) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else if (ACK_TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

    // A fresh edge on the bit being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | edge_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= bus.req;  // lines held high through reset do not fire
      pending_q     <= 8'h00;
      irq_q         <= 1'b0;
      irq_id_q      <= 3'd0;
      in_service_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      pending_q     <= pending_d;
      irq_q         <= irq_d;
      irq_id_q      <= irq_id_d;
      in_service_q  <= in_service_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.irq         = irq_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.pending     = pending_q;
  assign bus.in_service  = in_service_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_irq_edge_arbiter8.sv
// tb/tb_irq_edge_arbiter8.sv - directed self-checking bench for irq_edge_arbiter8
module tb_irq_edge_arbiter8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  irq_edge_arbiter8_if bus_if ();

  irq_edge_arbiter8 #(.ACK_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs driven after this are stable before the next edge
  // and outputs read after it are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.req = 8'hFF;
    tick(); tick();
    checks++;
    if ({bus_if.irq, bus_if.irq_id, bus_if.pending, bus_if.in_service, bus_if.timeout_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got irq=%b id=%0d pend=%h insvc=%b terr=%b, want all 0",
               bus_if.irq, bus_if.irq_id, bus_if.pending, bus_if.in_service, bus_if.timeout_err);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (bus_if.pending !== 8'h00 || bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_req: got pend=%h irq=%b, want pend=00 irq=0", bus_if.pending, bus_if.irq);
    end
    bus_if.req = 8'h00;
    tick();
    bus_if.ack = 1'b1;
    bus_if.eoi = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    bus_if.eoi = 1'b0;
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.in_service !== 1'b0 || bus_if.pending !== 8'h00 || bus_if.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_eoi: got irq=%b insvc=%b pend=%h terr=%b, want 0 0 00 0",
               bus_if.irq, bus_if.in_service, bus_if.pending, bus_if.timeout_err);
    end
  endtask

  task automatic test_single();
    bus_if.req = 8'h08;
    tick();
    bus_if.req = 8'h00;
    checks++;
    if (bus_if.pending !== 8'h08 || bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: got pend=%h irq=%b, want pend=08 irq=0", bus_if.pending, bus_if.irq);
    end
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd3) begin
      errors++;
      $display("FAIL single_e1: got irq=%b id=%0d, want irq=1 id=3", bus_if.irq, bus_if.irq_id);
    end
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.in_service !== 1'b1 || bus_if.pending !== 8'h00 || bus_if.irq_id !== 3'd3) begin
      errors++;
      $display("FAIL single_ack: got irq=%b insvc=%b pend=%h id=%0d, want 0 1 00 3",
               bus_if.irq, bus_if.in_service, bus_if.pending, bus_if.irq_id);
    end
    tick();
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
    checks++;
    if (bus_if.in_service !== 1'b0 || bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL single_eoi: got insvc=%b irq=%b, want 0 0", bus_if.in_service, bus_if.irq);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_id [3];
    logic [7:0] exp_pend [3];
    exp_id   = '{3'd7, 3'd2, 3'd0};
    exp_pend = '{8'h05, 8'h01, 8'h00};
    bus_if.req = 8'h85;
    tick();
    bus_if.req = 8'h00;
    checks++;
    if (bus_if.pending !== 8'h85) begin
      errors++;
      $display("FAIL prio_pend0: got %h, want 85", bus_if.pending);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_if.irq !== 1'b1 || bus_if.irq_id !== exp_id[i]) begin
        errors++;
        $display("FAIL prio_irq%0d: got irq=%b id=%0d, want irq=1 id=%0d", i, bus_if.irq, bus_if.irq_id, exp_id[i]);
      end
      bus_if.ack = 1'b1;
      tick();
      bus_if.ack = 1'b0;
      checks++;
      if (bus_if.pending !== exp_pend[i]) begin
        errors++;
        $display("FAIL prio_pend%0d: got %h, want %h", i, bus_if.pending, exp_pend[i]);
      end
      bus_if.eoi = 1'b1;
      tick();
      bus_if.eoi = 1'b0;
      checks++;
      if (bus_if.irq !== 1'b0) begin
        errors++;
        $display("FAIL prio_gap%0d: got irq=%b, want 0", i, bus_if.irq);
      end
      tick();
    end
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL prio_done: got irq=%b, want 0", bus_if.irq);
    end
  endtask

  task automatic test_mask();
    bus_if.mask = 8'h40;
    bus_if.req  = 8'h42;
    tick();
    bus_if.req = 8'h00;
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd1) begin
      errors++;
      $display("FAIL mask_id: got irq=%b id=%0d, want irq=1 id=1", bus_if.irq, bus_if.irq_id);
    end
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    checks++;
    if (bus_if.pending !== 8'h40) begin
      errors++;
      $display("FAIL mask_pend: got %h, want 40", bus_if.pending);
    end
    bus_if.mask = 8'h00;
    tick();
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd6) begin
      errors++;
      $display("FAIL mask_unmask: got irq=%b id=%0d, want irq=1 id=6", bus_if.irq, bus_if.irq_id);
    end
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus_if.req = 8'h10;
    tick();
    bus_if.req = 8'h00;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd4 || bus_if.timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_high%0d: got irq=%b id=%0d terr=%b, want 1 4 0", c, bus_if.irq, bus_if.irq_id, bus_if.timeout_err);
      end
      if (c < 4) tick();
    end
    tick();
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.timeout_err !== 1'b1 || bus_if.pending !== 8'h10) begin
      errors++;
      $display("FAIL tmo_fire: got irq=%b terr=%b pend=%h, want 0 1 10", bus_if.irq, bus_if.timeout_err, bus_if.pending);
    end
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd4 || bus_if.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_represent: got irq=%b id=%0d terr=%b, want 1 4 0", bus_if.irq, bus_if.irq_id, bus_if.timeout_err);
    end
    tick(); tick(); tick();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.in_service !== 1'b1 || bus_if.timeout_err !== 1'b0 || bus_if.pending !== 8'h00) begin
      errors++;
      $display("FAIL tmo_last_ack: got irq=%b insvc=%b terr=%b pend=%h, want 0 1 0 00",
               bus_if.irq, bus_if.in_service, bus_if.timeout_err, bus_if.pending);
    end
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
  endtask

  task automatic test_en_abort();
    bus_if.req = 8'h01;
    tick();
    bus_if.req = 8'h00;
    tick();
    bus_if.en = 1'b0;
    tick();
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.timeout_err !== 1'b0 || bus_if.pending !== 8'h01) begin
      errors++;
      $display("FAIL abort_drop: got irq=%b terr=%b pend=%h, want 0 0 01", bus_if.irq, bus_if.timeout_err, bus_if.pending);
    end
    tick();
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got irq=%b, want 0", bus_if.irq);
    end
    bus_if.en = 1'b1;
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd0) begin
      errors++;
      $display("FAIL abort_resume: got irq=%b id=%0d, want 1 0", bus_if.irq, bus_if.irq_id);
    end
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus_if.req = 8'h20;
    tick();
    bus_if.req = 8'h00;
    tick();
    bus_if.ack = 1'b1;
    bus_if.req = 8'h20;
    tick();
    bus_if.ack = 1'b0;
    bus_if.req = 8'h00;
    checks++;
    if (bus_if.pending !== 8'h20 || bus_if.in_service !== 1'b1 || bus_if.irq !== 1'b0) begin
      errors++;
      $display("FAIL repend_keep: got pend=%h insvc=%b irq=%b, want 20 1 0", bus_if.pending, bus_if.in_service, bus_if.irq);
    end
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_id !== 3'd5) begin
      errors++;
      $display("FAIL repend_reserve: got irq=%b id=%0d, want 1 5", bus_if.irq, bus_if.irq_id);
    end
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_service();
    bus_if.req = 8'h02;
    tick();
    bus_if.req = 8'h00;
    tick();
    bus_if.ack = 1'b1;
    bus_if.req = 8'h80;
    tick();
    bus_if.ack = 1'b0;
    bus_if.req = 8'h00;
    checks++;
    if (bus_if.in_service !== 1'b1 || bus_if.pending !== 8'h80) begin
      errors++;
      $display("FAIL rstsvc_pre: got insvc=%b pend=%h, want 1 80", bus_if.in_service, bus_if.pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus_if.irq, bus_if.irq_id, bus_if.pending, bus_if.in_service, bus_if.timeout_err} !== 13'd0) begin
      errors++;
      $display("FAIL rstsvc_clear: got irq=%b id=%0d pend=%h insvc=%b terr=%b, want all 0",
               bus_if.irq, bus_if.irq_id, bus_if.pending, bus_if.in_service, bus_if.timeout_err);
    end
    tick(); tick();
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.pending !== 8'h00) begin
      errors++;
      $display("FAIL rstsvc_after: got irq=%b pend=%h, want 0 00", bus_if.irq, bus_if.pending);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus_if.en   = 1'b1;
    bus_if.req  = 8'h00;
    bus_if.mask = 8'h00;
    bus_if.ack  = 1'b0;
    bus_if.eoi  = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_timeout();
    test_en_abort();
    test_back_to_back();
    test_reset_in_service();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
